// File: rtl/tx_data_field_sequencer_pkg.sv
// Shared types and constants for the 802.11a TX DATA field sequencer.
//   RATE code -> N_DBPS lookup, FSM state encoding, default scrambler seed,
//   counter widths and fixed field lengths.
package tx_data_field_sequencer_pkg;

    localparam int unsigned CNT_W        = 16;
    localparam int unsigned NSYM_W       = 11;
    localparam int unsigned LEN_W        = 12;
    localparam int unsigned RATE_W       = 4;
    localparam int unsigned DBPS_W       = 8;
    localparam int unsigned SEED_W       = 7;
    localparam int unsigned SERVICE_BITS = 16;
    localparam int unsigned TAIL_BITS    = 6;

    localparam logic [SEED_W-1:0] SEED_DEFAULT = 7'b1011101;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CALC    = 3'd1,
        S_LOAD    = 3'd2,
        S_SERVICE = 3'd3,
        S_PSDU    = 3'd4,
        S_TAIL    = 3'd5,
        S_PAD     = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    // Data bits per OFDM symbol; zero marks an invalid RATE code.
    function automatic logic [DBPS_W-1:0] ndbps_lut(input logic [RATE_W-1:0] rate);
        case (rate)
            4'b1101: return 8'd24;
            4'b1111: return 8'd36;
            4'b0101: return 8'd48;
            4'b0111: return 8'd72;
            4'b1001: return 8'd96;
            4'b1011: return 8'd144;
            4'b0001: return 8'd192;
            4'b0011: return 8'd216;
            default: return 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/tx_data_field_sequencer_if.sv
// Bus between the PSDU source / TX scrambler / downstream encoder and the
// DATA field sequencer.
//   master : environment side (drives start/rate/length/data/ready/scrambler out)
//   slave  : sequencer side
interface tx_data_field_sequencer_if;
    import tx_data_field_sequencer_pkg::*;

    logic                iStart;
    logic [RATE_W-1:0]   iRate;
    logic [LEN_W-1:0]    iLength;
    logic                iData;
    logic                iReady;
    logic                iSCMB_Out;
    logic                oDataReq;
    logic                oSCMB_Load;
    logic [SEED_W-1:0]   oSCMB_Seed;
    logic                oSCMB_SEN;
    logic                oSCMB_In;
    logic                oData;
    logic                oValid;
    logic [NSYM_W-1:0]   oNSym;
    logic                oBusy;
    logic                oDone;
    logic                oErr;

    modport master (
        output iStart, iRate, iLength, iData, iReady, iSCMB_Out,
        input  oDataReq, oSCMB_Load, oSCMB_Seed, oSCMB_SEN, oSCMB_In,
               oData, oValid, oNSym, oBusy, oDone, oErr
    );

    modport slave (
        input  iStart, iRate, iLength, iData, iReady, iSCMB_Out,
        output oDataReq, oSCMB_Load, oSCMB_Seed, oSCMB_SEN, oSCMB_In,
               oData, oValid, oNSym, oBusy, oDone, oErr
    );

endinterface

// File: rtl/tx_data_field_sequencer_calc.sv
// Iterative N_SYM / pad computation without a divider.
//   clk, rst       : clock, async active-high reset
//   start          : one-cycle pulse, samples ndbps and length
//   ndbps, length  : data bits per symbol, PSDU octets
//   done           : one-cycle pulse, nsym/pad valid from this cycle on
//   nsym, pad      : symbol count and pad bits for the frame
module tx_data_field_sequencer_calc
    import tx_data_field_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DBPS_W-1:0] ndbps,
    input  logic [LEN_W-1:0]  length,
    output logic              done,
    output logic [NSYM_W-1:0] nsym,
    output logic [CNT_W-1:0]  pad
);

    logic              busy_q,  busy_d;
    logic              done_q,  done_d;
    logic [DBPS_W-1:0] dbps_q,  dbps_d;
    logic [CNT_W-1:0]  acc_q,   acc_d;
    logic [CNT_W-1:0]  nbits_q, nbits_d;
    logic [CNT_W-1:0]  pad_q,   pad_d;
    logic [NSYM_W-1:0] nsym_q,  nsym_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbps_q  <= '0;
            acc_q   <= '0;
            nbits_q <= '0;
            pad_q   <= '0;
            nsym_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbps_q  <= dbps_d;
            acc_q   <= acc_d;
            nbits_q <= nbits_d;
            pad_q   <= pad_d;
            nsym_q  <= nsym_d;
        end
    end

    // First symbol is counted at start; one more symbol per cycle until the
    // accumulated capacity covers SERVICE + PSDU + tail.
    always_comb begin
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbps_d  = dbps_q;
        acc_d   = acc_q;
        nbits_d = nbits_q;
        pad_d   = pad_q;
        nsym_d  = nsym_q;
        if (start) begin
            busy_d  = 1'b1;
            dbps_d  = ndbps;
            acc_d   = CNT_W'(ndbps);
            nsym_d  = NSYM_W'(1);
            nbits_d = CNT_W'(SERVICE_BITS + TAIL_BITS) + CNT_W'({length, 3'b000});
        end else if (busy_q) begin
            if (acc_q >= nbits_q) begin
                busy_d = 1'b0;
                done_d = 1'b1;
                pad_d  = acc_q - nbits_q;
            end else begin
                acc_d  = acc_q + CNT_W'(dbps_q);
                nsym_d = nsym_q + NSYM_W'(1);
            end
        end
    end

    assign done = done_q;
    assign nsym = nsym_q;
    assign pad  = pad_q;

endmodule

// File: rtl/tx_data_field_sequencer.sv
// 802.11a TX DATA field sequencer: SERVICE, PSDU, tail, pad, feeding the
// external scrambler and forcing the scrambled tail to zero.
//   iClk, iRst : clock, async active-high reset
//   bus        : start/rate/length, PSDU bit source, scrambler hookup,
//                sequenced output with valid/ready, status (nsym/busy/done/err)
module tx_data_field_sequencer
    import tx_data_field_sequencer_pkg::*;
#(
    parameter logic [SEED_W-1:0] SEED = SEED_DEFAULT
) (
    input  logic                      iClk,
    input  logic                      iRst,
    tx_data_field_sequencer_if.slave  bus
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  pad_q, pad_d;
    logic [CNT_W-1:0]  psdu_bits_q, psdu_bits_d;
    logic [NSYM_W-1:0] nsym_q, nsym_d;
    logic              err_q, err_d;

    logic              calc_start_c;
    logic              calc_done;
    logic [NSYM_W-1:0] calc_nsym;
    logic [CNT_W-1:0]  calc_pad;
    logic [DBPS_W-1:0] start_dbps_c;
    logic [CNT_W-1:0]  field_last_c;
    state_e            field_next_c;
    logic              valid_c;
    logic              xfer_c;

    tx_data_field_sequencer_calc u_calc (
        .clk    (iClk),
        .rst    (iRst),
        .start  (calc_start_c),
        .ndbps  (start_dbps_c),
        .length (bus.iLength),
        .done   (calc_done),
        .nsym   (calc_nsym),
        .pad    (calc_pad)
    );

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pad_q       <= '0;
            psdu_bits_q <= '0;
            nsym_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pad_q       <= pad_d;
            psdu_bits_q <= psdu_bits_d;
            nsym_q      <= nsym_d;
            err_q       <= err_d;
        end
    end

    assign valid_c = (state_q == S_SERVICE) || (state_q == S_PSDU) ||
                     (state_q == S_TAIL)    || (state_q == S_PAD);
    assign xfer_c  = valid_c & bus.iReady;

    // Next-state and field counter; fields are only entered with a nonzero length.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pad_d        = pad_q;
        psdu_bits_d  = psdu_bits_q;
        nsym_d       = nsym_q;
        err_d        = 1'b0;
        calc_start_c = 1'b0;
        field_last_c = '0;
        field_next_c = S_DONE;
        start_dbps_c = ndbps_lut(bus.iRate);

        case (state_q)
            S_IDLE: begin
                if (bus.iStart) begin
                    if (start_dbps_c != '0) begin
                        calc_start_c = 1'b1;
                        psdu_bits_d  = CNT_W'({bus.iLength, 3'b000});
                        state_d      = S_CALC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_CALC: begin
                if (calc_done) begin
                    nsym_d  = calc_nsym;
                    pad_d   = calc_pad;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SERVICE;
            end
            S_SERVICE: begin
                field_last_c = CNT_W'(SERVICE_BITS - 1);
                field_next_c = (psdu_bits_q == '0) ? S_TAIL : S_PSDU;
            end
            S_PSDU: begin
                field_last_c = psdu_bits_q - CNT_W'(1);
                field_next_c = S_TAIL;
            end
            S_TAIL: begin
                field_last_c = CNT_W'(TAIL_BITS - 1);
                field_next_c = (pad_q == '0) ? S_DONE : S_PAD;
            end
            S_PAD: begin
                field_last_c = pad_q - CNT_W'(1);
                field_next_c = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (xfer_c) begin
            if (cnt_q == field_last_c) begin
                cnt_d   = '0;
                state_d = field_next_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Scrambler still shifts through the tail; only the emitted bit is zeroed.
    assign bus.oValid     = valid_c;
    assign bus.oSCMB_SEN  = xfer_c;
    assign bus.oDataReq   = (state_q == S_PSDU);
    assign bus.oSCMB_In   = (state_q == S_PSDU) & bus.iData;
    assign bus.oData      = valid_c & (state_q != S_TAIL) & bus.iSCMB_Out;
    assign bus.oSCMB_Load = (state_q == S_LOAD);
    assign bus.oSCMB_Seed = SEED;
    assign bus.oNSym      = nsym_q;
    assign bus.oBusy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.oDone      = (state_q == S_DONE);
    assign bus.oErr       = err_q;

endmodule

// File: tb/tb_tx_data_field_sequencer.sv
// Directed bench for the DATA field sequencer with an external scrambler
// model, a PSDU bit source and a golden bitstream reference.
module tb_tx_data_field_sequencer;

    logic clk;
    logic rst;

    tx_data_field_sequencer_if bus();

    tx_data_field_sequencer dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  psdu_mem [0:4095];
    logic [6:0]  scr_q;
    logic        mon_clr;
    logic [15:0] dreq_cnt;
    int          xfer_cnt;
    int          done_cnt;
    int          err_cnt;
    int          load_cnt;
    logic        valid_seen;
    logic        got_q [$];
    logic [7:0]  src_byte;

    // External scrambler x^7 + x^4 + 1
    always @(posedge clk) begin
        if (bus.oSCMB_Load)     scr_q <= bus.oSCMB_Seed;
        else if (bus.oSCMB_SEN) scr_q <= {scr_q[5:0], scr_q[6] ^ scr_q[3]};
    end
    assign bus.iSCMB_Out = bus.oSCMB_In ^ scr_q[6] ^ scr_q[3];

    // PSDU source, LSB first, advanced on consumed bits
    always_comb begin
        src_byte = psdu_mem[dreq_cnt[14:3]];
        bus.iData = src_byte[dreq_cnt[2:0]];
    end

    always @(posedge clk) begin
        if (mon_clr) begin
            dreq_cnt   <= '0;
            xfer_cnt   <= 0;
            done_cnt   <= 0;
            err_cnt    <= 0;
            load_cnt   <= 0;
            valid_seen <= 1'b0;
            got_q.delete();
        end else begin
            if (bus.oValid && bus.iReady) begin
                got_q.push_back(bus.oData);
                xfer_cnt <= xfer_cnt + 1;
            end
            if (bus.oDataReq && bus.iReady) dreq_cnt <= dreq_cnt + 16'd1;
            if (bus.oDone)      done_cnt <= done_cnt + 1;
            if (bus.oErr)       err_cnt  <= err_cnt + 1;
            if (bus.oSCMB_Load) load_cnt <= load_cnt + 1;
            if (bus.oValid)     valid_seen <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        @(negedge clk);
        mon_clr = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
    endtask

    task automatic run_frame(input string nm, input logic [3:0] rate, input int len,
                             input int dbps, input int exp_nsym, input int exp_pad,
                             input int stall_at);
        int         cyc;
        int         mism;
        int         nb;
        logic       stalled;
        logic       hold;
        logic       fb;
        logic       raw;
        logic       expb;
        logic [6:0] s;
        logic [7:0] b;
        logic [5:0] tail;
        clear_mon();
        bus.iRate   = rate;
        bus.iLength = 12'(len);
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart  = 1'b0;
        chk({nm, "_busy"}, 32'(bus.oBusy), 32'd1);
        cyc = 0;
        stalled = 1'b0;
        while (done_cnt == 0 && cyc < 4000) begin
            if (stall_at >= 0 && !stalled && bus.oDataReq && dreq_cnt == 16'(stall_at)) begin
                stalled = 1'b1;
                hold = bus.oData;
                bus.iReady = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    chk({nm, "_stall_data"}, 32'(bus.oData), 32'(hold));
                    chk({nm, "_stall_sen"}, 32'(bus.oSCMB_SEN), 32'd0);
                    chk({nm, "_stall_req"}, 32'(bus.oDataReq), 32'd1);
                end
                bus.iReady = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_done_cnt"}, 32'(done_cnt), 32'd1);
        chk({nm, "_busy_end"}, 32'(bus.oBusy), 32'd0);
        chk({nm, "_nsym"}, 32'(bus.oNSym), 32'(exp_nsym));
        chk({nm, "_xfers"}, 32'(xfer_cnt), 32'(exp_nsym * dbps));
        chk({nm, "_dreq"}, 32'(dreq_cnt), 32'(8 * len));
        chk({nm, "_pad"}, 32'(xfer_cnt - 22 - 8 * len), 32'(exp_pad));
        chk({nm, "_load"}, 32'(load_cnt), 32'd1);
        chk({nm, "_err"}, 32'(err_cnt), 32'd0);
        nb = exp_nsym * dbps;
        mism = 0;
        tail = '0;
        s = 7'b1011101;
        if (got_q.size() < nb) begin
            mism = nb - got_q.size();
        end else begin
            for (int i = 0; i < nb; i++) begin
                if (i >= 16 && i < 16 + 8 * len) begin
                    b = psdu_mem[(i - 16) / 8];
                    raw = b[(i - 16) % 8];
                end else begin
                    raw = 1'b0;
                end
                fb = s[6] ^ s[3];
                expb = raw ^ fb;
                if (i >= 16 + 8 * len && i < 22 + 8 * len) begin
                    expb = 1'b0;
                    tail[i - 16 - 8 * len] = got_q[i];
                end
                s = {s[5:0], fb};
                if (got_q[i] !== expb) mism++;
            end
        end
        chk({nm, "_stream_mism"}, 32'(mism), 32'd0);
        chk({nm, "_tail_zero"}, 32'(tail), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) psdu_mem[i] = 8'((i * 37 + 5) ^ (i >> 3));
        rst         = 1'b1;
        mon_clr     = 1'b1;
        bus.iStart  = 1'b0;
        bus.iRate   = 4'b0000;
        bus.iLength = 12'd0;
        bus.iReady  = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_outputs",
            32'({bus.oValid, bus.oBusy, bus.oDataReq, bus.oData, bus.oSCMB_Load,
                 bus.oSCMB_SEN, bus.oDone, bus.oErr, bus.oSCMB_In, bus.oNSym}), 32'd0);
        chk("seed", 32'(bus.oSCMB_Seed), 32'h5D);
        rst     = 1'b0;
        mon_clr = 1'b0;

        run_frame("r1101_l1",   4'b1101, 1,   24,  2, 18, -1);
        run_frame("r0011_l100", 4'b0011, 100, 216, 4, 42, -1);
        run_frame("r1101_l0",   4'b1101, 0,   24,  1, 2,  -1);
        run_frame("r0101_l50",  4'b0101, 50,  48,  9, 10, -1);

        // Invalid rate
        clear_mon();
        bus.iRate  = 4'b0000;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        repeat (20) @(negedge clk);
        chk("bad_rate_err",   32'(err_cnt),    32'd1);
        chk("bad_rate_load",  32'(load_cnt),   32'd0);
        chk("bad_rate_valid", 32'(valid_seen), 32'd0);
        chk("bad_rate_busy",  32'(bus.oBusy),  32'd0);

        run_frame("stall", 4'b0011, 100, 216, 4, 42, 300);

        // Reset in the middle of the PSDU
        clear_mon();
        bus.iRate   = 4'b0011;
        bus.iLength = 12'd100;
        bus.iStart  = 1'b1;
        @(negedge clk);
        bus.iStart  = 1'b0;
        for (int c = 0; c < 500 && dreq_cnt < 16'd20; c++) @(negedge clk);
        chk("pre_rst_req", 32'(bus.oDataReq), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_outputs",
            32'({bus.oValid, bus.oBusy, bus.oDataReq, bus.oData, bus.oSCMB_Load,
                 bus.oSCMB_SEN, bus.oDone, bus.oErr, bus.oSCMB_In, bus.oNSym}), 32'd0);
        @(negedge clk);
        chk("mid_rst_done", 32'(done_cnt), 32'd0);
        rst = 1'b0;
        run_frame("after_rst", 4'b1101, 1, 24, 2, 18, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
